// File: rtl/irrig_pkg.sv
// Shared types and constants for the multizone irrigation sequencer.
// Holds the sequencer state encoding, the usage increment amounts
// (normal vs. peak-sun) and the quota reset value helper.
package irrig_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } irrig_state_t;

    localparam int INC_NORMAL = 1;
    localparam int INC_PEAK   = 2;

    // Quotas come out of reset at all-ones so no zone is blocked before configuration.
    function automatic logic [31:0] quota_reset_value(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/zone_usage_bank.sv
// Per-zone usage and quota storage. Usage counts saturate at all-ones,
// a clear beats a same-cycle increment on the same zone, and
// out-of-range config/readback indices are ignored / read as zero.
module zone_usage_bank
    import irrig_pkg::*;
#(
    parameter int NUM_ZONES = 8,
    parameter int ZONE_W    = $clog2(NUM_ZONES),
    parameter int USAGE_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    input  logic                 inc_peak,
    input  logic [ZONE_W-1:0]    inc_zone,
    input  logic                 cfg_wr,
    input  logic                 usage_clr,
    input  logic [ZONE_W-1:0]    cfg_zone,
    input  logic [USAGE_W-1:0]   cfg_data,
    input  logic [ZONE_W-1:0]    rd_zone,
    output logic [USAGE_W-1:0]   rd_usage,
    output logic [USAGE_W-1:0]   rd_quota,
    output logic [NUM_ZONES-1:0] quota_exceeded
);

    localparam logic [USAGE_W-1:0] QUOTA_RST = USAGE_W'(quota_reset_value(USAGE_W));
    localparam logic [USAGE_W:0]   USAGE_MAX = {1'b0, {USAGE_W{1'b1}}};

    logic [USAGE_W-1:0] usage [NUM_ZONES];
    logic [USAGE_W-1:0] quota [NUM_ZONES];
    logic [USAGE_W:0]   inc_sum;
    logic [USAGE_W-1:0] usage_sat;
    logic               rd_in_range;

    // Saturating add of the active zone's usage; one extra bit catches overflow.
    always_comb begin
        inc_sum   = {1'b0, usage[inc_zone]}
                  + (inc_peak ? (USAGE_W+1)'(INC_PEAK) : (USAGE_W+1)'(INC_NORMAL));
        usage_sat = (inc_sum > USAGE_MAX) ? USAGE_MAX[USAGE_W-1:0] : inc_sum[USAGE_W-1:0];
    end

    // Usage update: clear has priority over an increment to the same zone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ZONES; i++) usage[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                if (usage_clr && (cfg_zone == ZONE_W'(i)))
                    usage[i] <= '0;
                else if (inc_en && (inc_zone == ZONE_W'(i)))
                    usage[i] <= usage_sat;
            end
        end
    end

    // Quota writes; an index with no matching zone simply matches nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ZONES; i++) quota[i] <= QUOTA_RST;
        end else begin
            for (int i = 0; i < NUM_ZONES; i++) begin
                if (cfg_wr && (cfg_zone == ZONE_W'(i)))
                    quota[i] <= cfg_data;
            end
        end
    end

    // Quota comparison straight from the storage registers.
    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++) quota_exceeded[i] = (usage[i] >= quota[i]);
    end

    assign rd_in_range = ({1'b0, rd_zone} < (ZONE_W+1)'(NUM_ZONES));

    // Registered readback, zero for indices past the last zone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_usage <= '0;
            rd_quota <= '0;
        end else begin
            rd_usage <= rd_in_range ? usage[rd_zone] : '0;
            rd_quota <= rd_in_range ? quota[rd_zone] : '0;
        end
    end

endmodule

// File: rtl/multizone_irrigation_sequencer.sv
// Multizone irrigation sequencer: scans zones in ascending order, waters each
// eligible zone, and keeps every valve closed for SETTLE_CYCLES between zones.
// Optional run-time limit per zone is enabled by defining IRR_RUN_LIMIT_EN.
// cycle_start / cycle_abort are single-cycle requests sampled on each clock;
// there is no back-pressure: start is dropped while busy, abort wins over start.
module multizone_irrigation_sequencer
    import irrig_pkg::*;
#(
    parameter int NUM_ZONES     = 8,
    parameter int ZONE_W        = $clog2(NUM_ZONES),
    parameter int USAGE_W       = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RUN_TICKS = 600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flow_pulse,
    input  logic                 peak_time,
    input  logic                 tick,
    input  logic                 rain,
    input  logic [NUM_ZONES-1:0] moisture_dry,
    input  logic [NUM_ZONES-1:0] zone_mask,
    input  logic                 cycle_start,
    input  logic                 cycle_abort,
    input  logic                 cfg_wr,
    input  logic                 usage_clr,
    input  logic [ZONE_W-1:0]    cfg_zone,
    input  logic [USAGE_W-1:0]   cfg_data,
    input  logic [ZONE_W-1:0]    rd_zone,
    output logic [USAGE_W-1:0]   rd_usage,
    output logic [USAGE_W-1:0]   rd_quota,
    output logic [NUM_ZONES-1:0] valve_on,
    output logic [ZONE_W-1:0]    active_zone,
    output logic                 busy,
    output logic [NUM_ZONES-1:0] quota_exceeded,
    output logic [NUM_ZONES-1:0] timeout_flag,
    output logic                 cycle_done,
    output logic [2:0]           dbg_state
);

    localparam logic [ZONE_W-1:0] LAST_ZONE   = ZONE_W'(NUM_ZONES - 1);
    localparam int                SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    irrig_state_t        state;
    logic [ZONE_W-1:0]   idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                eligible;
    logic                run_stop;
    logic                limit_hit;
    logic                inc_en;

    assign eligible    = zone_mask[idx] & moisture_dry[idx] & ~rain & ~quota_exceeded[idx];
    assign run_stop    = ~moisture_dry[idx] | rain | quota_exceeded[idx] | limit_hit;
    assign inc_en      = flow_pulse & (|valve_on);
    assign busy        = (state != IDLE);
    assign active_zone = idx;
    assign dbg_state   = state;

    zone_usage_bank #(
        .NUM_ZONES (NUM_ZONES),
        .ZONE_W    (ZONE_W),
        .USAGE_W   (USAGE_W)
    ) u_bank (
        .clk            (clk),
        .rst            (rst),
        .inc_en         (inc_en),
        .inc_peak       (peak_time),
        .inc_zone       (idx),
        .cfg_wr         (cfg_wr),
        .usage_clr      (usage_clr),
        .cfg_zone       (cfg_zone),
        .cfg_data       (cfg_data),
        .rd_zone        (rd_zone),
        .rd_usage       (rd_usage),
        .rd_quota       (rd_quota),
        .quota_exceeded (quota_exceeded)
    );

`ifdef IRR_RUN_LIMIT_EN
    localparam int RUN_W = $clog2(MAX_RUN_TICKS + 1);
    logic [RUN_W-1:0] run_cnt;

    assign limit_hit = (state == RUN) && (run_cnt == RUN_W'(MAX_RUN_TICKS));

    // Tick counter for the current watering run; idle outside RUN so each zone starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            run_cnt <= '0;
        else if (state != RUN)
            run_cnt <= '0;
        else if (tick && (run_cnt != RUN_W'(MAX_RUN_TICKS)))
            run_cnt <= run_cnt + RUN_W'(1);
    end

    // Sticky record of zones cut off by the limit, cleared when a new cycle is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_flag <= '0;
        else if ((state == IDLE) && cycle_start && !cycle_abort)
            timeout_flag <= '0;
        else if (limit_hit && !cycle_abort)
            timeout_flag[idx] <= 1'b1;
    end
`else
    logic run_limit_unused;
    assign run_limit_unused = tick | (MAX_RUN_TICKS == 0);
    assign limit_hit        = 1'b0;
    assign timeout_flag     = '0;
`endif

    // Sequencer FSM: scan, run, settle, done; valves only change here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            valve_on   <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cycle_start && !cycle_abort) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (cycle_abort) begin
                        state <= DONE;
                    end else if (eligible) begin
                        state    <= RUN;
                        valve_on <= NUM_ZONES'(1) << idx;
                    end else if (idx == LAST_ZONE) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + ZONE_W'(1);
                    end
                end
                RUN: begin
                    if (cycle_abort) begin
                        state    <= DONE;
                        valve_on <= '0;
                    end else if (run_stop) begin
                        state      <= SETTLE;
                        valve_on   <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (cycle_abort) begin
                        state <= DONE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        if (idx == LAST_ZONE) begin
                            state <= DONE;
                        end else begin
                            state <= SCAN;
                            idx   <= idx + ZONE_W'(1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    cycle_done <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    valve_on <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multizone_irrigation_sequencer.sv
// Testbench for multizone_irrigation_sequencer (4 zones). Exercises the
// IRR_RUN_LIMIT_EN behaviour when that macro is defined, otherwise checks
// that tick has no effect. Expected valve order, settle gaps and usage come
// from a zone-level model of the watering rules.
module tb_multizone_irrigation_sequencer;

    localparam int NZ     = 4;
    localparam int ZW     = 2;
    localparam int UW     = 10;
    localparam int SETTLE = 16;
    localparam int MAXT   = 3;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          auto_pulse, man_pulse, flow_pulse;
    logic          peak_time, tick, rain;
    logic [NZ-1:0] moisture_dry, zone_mask;
    logic          cycle_start, cycle_abort, cfg_wr, usage_clr;
    logic [ZW-1:0] cfg_zone, rd_zone;
    logic [UW-1:0] cfg_data, rd_usage, rd_quota;
    logic [NZ-1:0] valve_on, quota_exceeded, timeout_flag;
    logic [ZW-1:0] active_zone;
    logic          busy, cycle_done;
    logic [2:0]    dbg_state;

    assign flow_pulse = auto_pulse | man_pulse;

    int checks = 0;
    int errors = 0;

    multizone_irrigation_sequencer #(
        .NUM_ZONES     (NZ),
        .ZONE_W        (ZW),
        .USAGE_W       (UW),
        .SETTLE_CYCLES (SETTLE),
        .MAX_RUN_TICKS (MAXT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flow_pulse     (flow_pulse),
        .peak_time      (peak_time),
        .tick           (tick),
        .rain           (rain),
        .moisture_dry   (moisture_dry),
        .zone_mask      (zone_mask),
        .cycle_start    (cycle_start),
        .cycle_abort    (cycle_abort),
        .cfg_wr         (cfg_wr),
        .usage_clr      (usage_clr),
        .cfg_zone       (cfg_zone),
        .cfg_data       (cfg_data),
        .rd_zone        (rd_zone),
        .rd_usage       (rd_usage),
        .rd_quota       (rd_quota),
        .valve_on       (valve_on),
        .active_zone    (active_zone),
        .busy           (busy),
        .quota_exceeded (quota_exceeded),
        .timeout_flag   (timeout_flag),
        .cycle_done     (cycle_done),
        .dbg_state      (dbg_state)
    );

    // ---------------- background flow source ----------------
    bit auto_en = 1'b0;
    int ph = 0;
    always @(negedge clk) begin
        if (auto_en) begin
            ph = (ph + 1) % 3;
            auto_pulse = (ph == 0);
        end else begin
            auto_pulse = 1'b0;
        end
    end

    // ---------------- valve monitor (scoreboard inputs) ----------------
    logic [NZ-1:0] obs_q[$];
    int            gap_q[$];
    logic [NZ-1:0] prev_valve = '0;
    int            zero_run = 0;
    bit            had_open = 1'b0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cycle_done) done_cnt++;
            if (valve_on != '0) begin
                checks++;
                if (!$onehot(valve_on)) begin
                    errors++;
                    $display("FAIL valve_onehot: got %b required one-hot", valve_on);
                end
                if (prev_valve == '0) begin
                    obs_q.push_back(valve_on);
                    if (had_open) gap_q.push_back(zero_run);
                    had_open = 1'b1;
                end else if (valve_on != prev_valve) begin
                    errors++;
                    $display("FAIL break_before_make: %b -> %b with no closed gap", prev_valve, valve_on);
                end
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_valve = valve_on;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mon_clear();
        obs_q.delete();
        gap_q.delete();
        had_open = 1'b0;
        zero_run = 0;
        done_cnt = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_zone_write(input int z, input int q);
        cfg_zone  = ZW'(z);
        cfg_data  = UW'(q);
        cfg_wr    = 1'b1;
        usage_clr = 1'b1;
        @(negedge clk);
        cfg_wr    = 1'b0;
        usage_clr = 1'b0;
    endtask

    task automatic start_cycle();
        cycle_start = 1'b1;
        @(negedge clk);
        cycle_start = 1'b0;
    endtask

    task automatic read_zone(input int z, output logic [UW-1:0] u, output logic [UW-1:0] q);
        rd_zone = ZW'(z);
        @(negedge clk);
        @(negedge clk);
        u = rd_usage;
        q = rd_quota;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cycle_done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done_timeout: no cycle_done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valve(input logic [NZ-1:0] v, input int budget, input string name);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valve_on == v) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_valve_timeout: valve_on %b never reached %b", name, valve_on, v);
        end
    endtask

    // ---------------- reference-model scenario ----------------
    int quota_m[NZ];

    task automatic run_model_cycle(input logic [NZ-1:0] mask, input logic [NZ-1:0] dry,
                                   input bit pk, input string name);
        logic [NZ-1:0] exp_v[$];
        int            exp_gap[$];
        int            exp_use[NZ];
        int            inc, prev_z;
        logic [UW-1:0] u, q;
        for (int z = 0; z < NZ; z++) cfg_zone_write(z, quota_m[z]);
        zone_mask    = mask;
        moisture_dry = dry;
        peak_time    = pk;
        rain         = 1'b0;
        mon_clear();
        auto_en = 1'b1;
        start_cycle();
        wait_done(3000, name);
        auto_en = 1'b0;
        idle_cycles(2);

        // Zone-level model: eligible zones open in ascending order, each is fed
        // pulses until usage first reaches its quota; the closed gap is the settle
        // time plus one scan cycle per zone index advanced.
        inc    = pk ? 2 : 1;
        prev_z = -1;
        for (int z = 0; z < NZ; z++) begin
            if (mask[z] && dry[z] && quota_m[z] > 0) begin
                exp_v.push_back(NZ'(1) << z);
                if (prev_z >= 0) exp_gap.push_back(SETTLE + z - prev_z);
                prev_z     = z;
                exp_use[z] = ((quota_m[z] + inc - 1) / inc) * inc;
            end else begin
                exp_use[z] = 0;
            end
        end

        checks++;
        if (obs_q.size() != exp_v.size()) begin
            errors++;
            $display("FAIL %s_open_count: got %0d required %0d", name, obs_q.size(), exp_v.size());
        end else begin
            for (int k = 0; k < exp_v.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL %s_open_order[%0d]: got %b required %b", name, k, obs_q[k], exp_v[k]);
                end
            end
        end
        checks++;
        if (gap_q.size() != exp_gap.size()) begin
            errors++;
            $display("FAIL %s_gap_count: got %0d required %0d", name, gap_q.size(), exp_gap.size());
        end else begin
            for (int k = 0; k < exp_gap.size(); k++) begin
                checks++;
                if (gap_q[k] != exp_gap[k]) begin
                    errors++;
                    $display("FAIL %s_gap[%0d]: got %0d required %0d", name, k, gap_q[k], exp_gap[k]);
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt);
        end
        for (int z = 0; z < NZ; z++) begin
            read_zone(z, u, q);
            checks++;
            if (u !== UW'(exp_use[z])) begin
                errors++;
                $display("FAIL %s_usage[%0d]: got %0d required %0d", name, z, u, exp_use[z]);
            end
            checks++;
            if (q !== UW'(quota_m[z])) begin
                errors++;
                $display("FAIL %s_quota[%0d]: got %0d required %0d", name, z, q, quota_m[z]);
            end
            checks++;
            if (quota_exceeded[z] !== (exp_use[z] >= quota_m[z])) begin
                errors++;
                $display("FAIL %s_exceeded[%0d]: got %b required %b", name, z, quota_exceeded[z],
                         (exp_use[z] >= quota_m[z]));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [UW-1:0] u, q;
        idle_cycles(3);
        checks++;
        if (valve_on !== '0 || busy !== 1'b0 || cycle_done !== 1'b0 || quota_exceeded !== '0 ||
            timeout_flag !== '0 || rd_usage !== '0 || rd_quota !== '0 || active_zone !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valve %b busy %b done %b qx %b to %b ru %0d rq %0d az %0d required all 0",
                     valve_on, busy, cycle_done, quota_exceeded, timeout_flag, rd_usage, rd_quota, active_zone);
        end
        rst = 1'b0;
        read_zone(2, u, q);
        checks++;
        if (u !== '0 || q !== {UW{1'b1}}) begin
            errors++;
            $display("FAIL reset_storage: usage %0d quota %0d required 0 and %0d", u, q, {UW{1'b1}});
        end
    endtask

    task automatic test_full_cycle();
        for (int z = 0; z < NZ; z++) quota_m[z] = 5;
        run_model_cycle(4'b1111, 4'b1111, 1'b0, "full_cycle");
    endtask

    task automatic test_skip();
        for (int z = 0; z < NZ; z++) quota_m[z] = 3;
        run_model_cycle(4'b1011, 4'b1101, 1'b0, "skip");
    endtask

    task automatic test_random_cycles();
        for (int it = 0; it < 6; it++) begin
            for (int z = 0; z < NZ; z++) quota_m[z] = $urandom_range(0, 6);
            run_model_cycle(NZ'($urandom_range(0, 15)), NZ'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_peak_quota();
        logic [UW-1:0] u, q;
        cfg_zone_write(0, 4);
        zone_mask    = 4'b0001;
        moisture_dry = 4'b1111;
        peak_time    = 1'b1;
        start_cycle();
        wait_valve(4'b0001, 10, "peak");
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        idle_cycles(2);
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        checks++;
        if (valve_on !== 4'b0001 || quota_exceeded[0] !== 1'b1) begin
            errors++;
            $display("FAIL peak_reach: valve %b qx0 %b required 0001 and 1", valve_on, quota_exceeded[0]);
        end
        @(negedge clk);
        checks++;
        if (valve_on !== 4'b0000) begin
            errors++;
            $display("FAIL peak_close: valve %b required 0000", valve_on);
        end
        wait_done(100, "peak");
        read_zone(0, u, q);
        checks++;
        if (u !== 10'd4) begin
            errors++;
            $display("FAIL peak_usage: got %0d required 4", u);
        end
        peak_time = 1'b0;
    endtask

    task automatic test_saturation();
        logic [UW-1:0] u, q;
        cfg_zone_write(0, 1023);
        zone_mask    = 4'b0001;
        moisture_dry = 4'b1111;
        peak_time    = 1'b1;
        rd_zone      = 2'd0;
        start_cycle();
        wait_valve(4'b0001, 10, "sat");
        man_pulse = 1'b1;
        repeat (511) @(negedge clk);
        man_pulse = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_usage !== 10'd1022 || valve_on !== 4'b0001) begin
            errors++;
            $display("FAIL sat_1022: usage %0d valve %b required 1022 and 0001", rd_usage, valve_on);
        end
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_usage !== 10'd1023 || valve_on !== 4'b0000 || quota_exceeded[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_1023: usage %0d valve %b qx0 %b required 1023, 0000, 1",
                     rd_usage, valve_on, quota_exceeded[0]);
        end
        wait_done(100, "sat");
        // clear racing an increment on the same zone
        cfg_zone_write(0, 1023);
        start_cycle();
        wait_valve(4'b0001, 10, "clr");
        man_pulse = 1'b1;
        @(negedge clk);
        man_pulse = 1'b0;
        @(negedge clk);
        man_pulse = 1'b1;
        usage_clr = 1'b1;
        cfg_zone  = 2'd0;
        @(negedge clk);
        man_pulse = 1'b0;
        usage_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_usage !== 10'd0) begin
            errors++;
            $display("FAIL clear_wins: usage %0d required 0", rd_usage);
        end
        cycle_abort = 1'b1;
        @(negedge clk);
        cycle_abort = 1'b0;
        wait_done(10, "clr");
        read_zone(0, u, q);
        checks++;
        if (u !== 10'd0) begin
            errors++;
            $display("FAIL clear_after_abort: usage %0d required 0", u);
        end
        peak_time = 1'b0;
    endtask

    task automatic test_rain();
        for (int z = 0; z < NZ; z++) cfg_zone_write(z, 1023);
        zone_mask    = 4'b1100;
        moisture_dry = 4'b1111;
        mon_clear();
        start_cycle();
        wait_valve(4'b0100, 20, "rain");
        idle_cycles(3);
        rain = 1'b1;
        @(negedge clk);
        checks++;
        if (valve_on !== 4'b0000) begin
            errors++;
            $display("FAIL rain_close: valve %b required 0000", valve_on);
        end
        wait_done(100, "rain");
        idle_cycles(2);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL rain_skip_later: openings %0d required 1", obs_q.size());
        end
        rain = 1'b0;
    endtask

    task automatic test_abort();
        for (int z = 0; z < NZ; z++) cfg_zone_write(z, 2);
        zone_mask    = 4'b0011;
        moisture_dry = 4'b1111;
        mon_clear();
        auto_en = 1'b1;
        start_cycle();
        wait_valve(4'b0001, 20, "abort");
        wait_valve(4'b0000, 40, "abort_settle");
        auto_en = 1'b0;
        idle_cycles(2);
        cycle_abort = 1'b1;
        @(negedge clk);
        cycle_abort = 1'b0;
        @(negedge clk);
        checks++;
        if (cycle_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_settle_done: done %b busy %b required 1 and 0", cycle_done, busy);
        end
        idle_cycles(30);
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL abort_no_more_valves: openings %0d required 1", obs_q.size());
        end
        // abort and start together while idle: stay idle
        cycle_start = 1'b1;
        cycle_abort = 1'b1;
        @(negedge clk);
        cycle_start = 1'b0;
        cycle_abort = 1'b0;
        idle_cycles(2);
        checks++;
        if (busy !== 1'b0 || valve_on !== 4'b0000) begin
            errors++;
            $display("FAIL abort_beats_start: busy %b valve %b required 0", busy, valve_on);
        end
    endtask

    task automatic test_run_limit();
        for (int z = 0; z < NZ; z++) cfg_zone_write(z, 1023);
        zone_mask    = 4'b0001;
        moisture_dry = 4'b1111;
        start_cycle();
        wait_valve(4'b0001, 10, "limit");
`ifdef IRR_RUN_LIMIT_EN
        for (int t = 0; t < MAXT; t++) begin
            checks++;
            if (valve_on !== 4'b0001) begin
                errors++;
                $display("FAIL limit_early_close: valve %b after %0d ticks required 0001", valve_on, t);
            end
            idle_cycles(2);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (valve_on !== 4'b0000 || timeout_flag !== 4'b0001) begin
            errors++;
            $display("FAIL limit_close: valve %b timeout %b required 0000 and 0001", valve_on, timeout_flag);
        end
        wait_done(100, "limit");
        idle_cycles(3);
        checks++;
        if (timeout_flag !== 4'b0001) begin
            errors++;
            $display("FAIL limit_sticky: timeout %b required 0001", timeout_flag);
        end
        zone_mask = 4'b0000;
        start_cycle();
        checks++;
        if (timeout_flag !== 4'b0000) begin
            errors++;
            $display("FAIL limit_clear_on_start: timeout %b required 0000", timeout_flag);
        end
        wait_done(20, "limit_clear");
`else
        for (int t = 0; t < MAXT + 3; t++) begin
            idle_cycles(2);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
        idle_cycles(2);
        checks++;
        if (valve_on !== 4'b0001 || timeout_flag !== 4'b0000) begin
            errors++;
            $display("FAIL no_limit: valve %b timeout %b required 0001 and 0000", valve_on, timeout_flag);
        end
        cycle_abort = 1'b1;
        @(negedge clk);
        cycle_abort = 1'b0;
        wait_done(10, "no_limit");
`endif
    endtask

    task automatic test_async_reset();
        logic [UW-1:0] u, q;
        cfg_zone_write(1, 500);
        zone_mask    = 4'b0010;
        moisture_dry = 4'b1111;
        start_cycle();
        wait_valve(4'b0010, 10, "arst");
        man_pulse = 1'b1;
        repeat (3) @(negedge clk);
        man_pulse = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valve_on !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: valve %b busy %b required 0", valve_on, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        read_zone(1, u, q);
        checks++;
        if (u !== '0 || q !== {UW{1'b1}}) begin
            errors++;
            $display("FAIL arst_storage: usage %0d quota %0d required 0 and %0d", u, q, {UW{1'b1}});
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst          = 1'b1;
        man_pulse    = 1'b0;
        auto_pulse   = 1'b0;
        peak_time    = 1'b0;
        tick         = 1'b0;
        rain         = 1'b0;
        moisture_dry = '0;
        zone_mask    = '0;
        cycle_start  = 1'b0;
        cycle_abort  = 1'b0;
        cfg_wr       = 1'b0;
        usage_clr    = 1'b0;
        cfg_zone     = '0;
        cfg_data     = '0;
        rd_zone      = '0;

        test_reset();
        test_full_cycle();
        test_skip();
        test_random_cycles();
        test_peak_quota();
        test_saturation();
        test_rain();
        test_abort();
        test_run_limit();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multizone_irrigation_sequencer.md
Name: multizone_irrigation_sequencer

Overview:
Parametrised next-generation irrigation controller for NUM_ZONES zones, with per-zone quota, per-zone usage accounting and per-zone moisture inputs. An automatic cycle scans zones in ascending index order, waters each eligible zone, and enforces a break-before-make settle gap between valves. It sits downstream of the flow-pulse debouncer and the time-of-day block, and drives one-hot valve outputs.

Parameters:
NUM_ZONES, 8, number of zones (2..16)
ZONE_W, $clog2(NUM_ZONES), zone index width
USAGE_W, 10, usage/quota width; saturating
SETTLE_CYCLES, 16, clk cycles all valves are closed between consecutive zones (>=1)
MAX_RUN_TICKS, 600, run-time limit in tick strobes (used only with IRR_RUN_LIMIT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
flow_pulse  in  1  debounced single-cycle flow strobe
peak_time  in  1  1 = peak sun; usage increments by 2 instead of 1
tick  in  1  1-second enable strobe (run limit)
rain  in  1  1 = raining; inhibits and stops watering
moisture_dry  in  NUM_ZONES  per-zone dry flag
zone_mask  in  NUM_ZONES  1 = zone takes part in the auto cycle
cycle_start  in  1  start a cycle; ignored while busy
cycle_abort  in  1  end the cycle immediately
cfg_wr  in  1  write quota[cfg_zone] = cfg_data
usage_clr  in  1  clear usage[cfg_zone]
cfg_zone  in  ZONE_W  config/clear target
cfg_data  in  USAGE_W  quota value
rd_zone  in  ZONE_W  readback select
rd_usage  out  USAGE_W  usage[rd_zone], 1-cycle latency
rd_quota  out  USAGE_W  quota[rd_zone], 1-cycle latency
valve_on  out  NUM_ZONES  one-hot or zero valve drive, registered
active_zone  out  ZONE_W  zone being scanned or watered
busy  out  1  1 whenever state != IDLE
quota_exceeded  out  NUM_ZONES  usage[i] >= quota[i], combinational from registers
timeout_flag  out  NUM_ZONES  sticky: zone stopped by run limit
cycle_done  out  1  1-cycle pulse on exit to IDLE

Behaviour:
- Reset: state IDLE; all usage = 0; all quota = all-ones; every output = 0. quota_exceeded follows from storage, so it is 0 after reset.
- Eligible(i) = zone_mask[i] & moisture_dry[i] & !rain & !quota_exceeded[i].
- IDLE: on cycle_start, go to SCAN with idx = 0 and clear timeout_flag.
- SCAN: evaluates one zone per cycle.
  - Eligible(idx): go to RUN; valve_on = 1<<idx on the same edge.
  - Otherwise, if idx = NUM_ZONES-1: go to DONE.
  - Otherwise: idx+1.
- RUN: exits to SETTLE when any of these holds: !moisture_dry[idx], rain, quota_exceeded[idx], or run limit. valve_on = 0 on that edge.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to SCAN with idx+1, or to DONE if idx was last.
- DONE: asserts cycle_done for one cycle, then IDLE.
- cycle_abort in SCAN, RUN or SETTLE goes to DONE next edge; valves close on that edge. If cycle_start and cycle_abort arrive together in IDLE, abort wins (stay IDLE).
- Accounting: a flow_pulse with any valve_on bit set adds (peak_time ? 2 : 1) to usage[idx].
  - Saturates at 2^USAGE_W-1; no wrap.
  - Pulses with all valves closed are ignored.
- Quota crossing mid-RUN: the pulse that reaches quota updates usage; the next edge closes the valve (1-cycle overshoot allowed). quota = 0 means the zone is never eligible.
- Same-cycle usage_clr and increment on the same zone: clear wins. cfg_wr and usage_clr may occur in any state; a write to the zone in RUN takes effect on the next exit evaluation.
- cfg_zone or rd_zone >= NUM_ZONES: write ignored, readback returns 0.
- Asynchronous rst mid-cycle closes all valves immediately and clears all usage.

Optional Feature:
IRR_RUN_LIMIT_EN
- Defined: a run counter clears on RUN entry and counts tick strobes. At MAX_RUN_TICKS it forces exit to SETTLE and sets timeout_flag[idx].
- Undefined: tick is ignored, there is no run limit, and timeout_flag is tied to 0.

Decomposition:
- Package irrig_pkg: state enum (IDLE, SCAN, RUN, SETTLE, DONE), increment constants INC_NORMAL=1 and INC_PEAK=2, and the quota reset value.
- Sub-module zone_usage_bank: usage/quota arrays, saturating add, clear/write arbitration, quota_exceeded vector and registered readback.
- The top level holds the FSM, settle counter and run counter.

Test Plan:
- NUM_ZONES=4, quotas=5, mask=1111, all dry, start -> valves 0001, 0010, 0100, 1000 in turn with >=16 all-zero cycles between them; cycle_done once.
- Zone 1 not dry, zone 2 masked -> only zones 0 and 3 open; scan skips 1 and 2 in one cycle each.
- Zone 0 quota=4, peak_time=1, two pulses -> usage 4, valve closes on the next edge, quota_exceeded[0]=1, rd_usage=4.
- usage at 1022 (USAGE_W=10), peak pulse -> 1023 saturated; usage_clr on the same cycle as a pulse -> 0.
- rain rises during RUN of zone 2 -> valve closes next edge, later zones skipped, cycle_done; cycle_abort mid-SETTLE -> DONE, no further valve.
- IRR_RUN_LIMIT_EN, MAX_RUN_TICKS=3, zone stays dry -> valve closes after 3 ticks, timeout_flag[idx]=1 until next cycle_start.
